// File: rtl/upg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : upg_pkg
//  Description : Shared types and constants for the UART program loader.
//                Optional checksum stage is enabled by UPG_CHECKSUM_EN.
//  Revision    : 1.0
// ============================================================================
package upg_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        DATA = 3'd3,
        CHK  = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } upg_state_e;

    // First word address of data memory (address MSB set)
    localparam logic [14:0] UPG_DMEM_BASE = 15'h4000;

    // Header carries a 16-bit little-endian word count
    localparam int UPG_HDR_BYTES = 2;

endpackage
`default_nettype wire

// File: rtl/upg_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : upg_word_assembler
//  Description : Packs a byte stream into 32-bit little-endian words. The
//                word is presented combinationally together with the fourth
//                byte so the caller can register it in the same edge.
//  Revision    : 1.0
// ============================================================================
module upg_word_assembler
    import upg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_word_ready,
    output logic [31:0] o_word_data
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q,   idx_d;

    // Fourth byte completes the word; earlier bytes already sit in shift_q
    assign o_word_ready = i_byte_valid && (idx_q == 2'd3);
    assign o_word_data  = {i_byte_data, shift_q};

    // Next-state: new bytes enter at the top so byte0 ends up in bits 7:0
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (i_clr) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (i_byte_valid) begin
            shift_d = {i_byte_data, shift_q[23:8]};
            idx_d   = idx_q + 2'd1;
        end
    end

    // Byte shift register and index flops
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/upg_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : upg_loader_ctrl
//  Description : UART download sequencer. Receives a 2-byte word count and
//                the word payload, writes each word to the upg_* memory port
//                with an auto-incrementing address while holding the CPU.
//                Define UPG_CHECKSUM_EN to add a trailing checksum byte check.
//  Revision    : 1.0
// ============================================================================
module upg_loader_ctrl
    import upg_pkg::*;
#(
    parameter int ADDR_W         = 15,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int MAX_WORDS      = 32768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              cpu_hold,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              busy,
    output logic              err
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    upg_state_e        state_q,  state_d;
    logic              start_prev_q;
    logic [15:0]       n_q,      n_d;
    logic [15:0]       wcount_q, wcount_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [TMO_W-1:0]  tmo_q,    tmo_d;
    logic              wen_q,    wen_d;
    logic [ADDR_W-1:0] adr_q,    adr_d;
    logic [31:0]       dat_q,    dat_d;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]        sum_q,    sum_d;
    logic [7:0]        w_sum_next;
    logic              w_sum_ok;
`endif

    logic        w_busy;
    logic        w_start;
    logic        w_last_pulse;
    logic        w_asm_valid;
    logic        w_word_ready;
    logic [31:0] w_word;
    logic [15:0] w_n_full;

    assign w_busy  = (state_q == HDR0) || (state_q == HDR1) ||
                     (state_q == DATA) || (state_q == CHK);
    assign w_start = prog_start && !start_prev_q && !w_busy;

    // The pulse cycle of the final word: counter has already reached N
    assign w_last_pulse = wen_q && (wcount_q == n_q);

    // Bytes after the final word are never part of the payload
    assign w_asm_valid = rx_valid && (state_q == DATA) && !w_last_pulse;
    assign w_n_full    = {rx_data, n_q[7:0]};

`ifdef UPG_CHECKSUM_EN
    assign w_sum_next = sum_q + rx_data;
    assign w_sum_ok   = (w_sum_next == 8'h00);
`endif

    upg_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_start),
        .i_byte_valid (w_asm_valid),
        .i_byte_data  (rx_data),
        .o_word_ready (w_word_ready),
        .o_word_data  (w_word)
    );

    // Next-state, counters, write port and timeout
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        wcount_d = wcount_q;
        addr_d   = addr_q;
        tmo_d    = tmo_q;
        wen_d    = 1'b0;
        adr_d    = adr_q;
        dat_d    = dat_q;
`ifdef UPG_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        if (w_busy) begin
            tmo_d = rx_valid ? '0 : tmo_q + TMO_W'(1);
        end

        case (state_q)
            IDLE, DONE, ERR: begin
                if (w_start) begin
                    state_d  = HDR0;
                    n_d      = '0;
                    wcount_d = '0;
                    addr_d   = '0;
                    tmo_d    = '0;
`ifdef UPG_CHECKSUM_EN
                    sum_d    = '0;
`endif
                end
            end
            HDR0: begin
                if (rx_valid) begin
                    n_d[7:0] = rx_data;
                    state_d  = HDR1;
`ifdef UPG_CHECKSUM_EN
                    sum_d    = w_sum_next;
`endif
                end
            end
            HDR1: begin
                if (rx_valid) begin
                    n_d[15:8] = rx_data;
`ifdef UPG_CHECKSUM_EN
                    sum_d     = w_sum_next;
`endif
                    if (w_n_full == 16'd0)
                        state_d = DONE;
                    else if ({16'd0, w_n_full} > 32'(MAX_WORDS))
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (w_word_ready) begin
                    wen_d    = 1'b1;
                    adr_d    = addr_q;
                    dat_d    = w_word;
                    addr_d   = addr_q + ADDR_W'(1);
                    wcount_d = wcount_q + 16'd1;
                end
`ifdef UPG_CHECKSUM_EN
                if (w_asm_valid) begin
                    sum_d = w_sum_next;
                end
                // A byte landing in the final pulse cycle is the checksum
                if (w_last_pulse) begin
                    if (rx_valid)
                        state_d = w_sum_ok ? DONE : ERR;
                    else
                        state_d = CHK;
                end
`else
                if (w_last_pulse) begin
                    state_d = DONE;
                end
`endif
            end
`ifdef UPG_CHECKSUM_EN
            CHK: begin
                if (rx_valid) begin
                    state_d = w_sum_ok ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Stalled link aborts; words already written are left in place
        if (w_busy && !rx_valid && (tmo_q == TMO_LAST)) begin
            state_d = ERR;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            n_q          <= '0;
            wcount_q     <= '0;
            addr_q       <= '0;
            tmo_q        <= '0;
            wen_q        <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= prog_start;
            n_q          <= n_d;
            wcount_q     <= wcount_d;
            addr_q       <= addr_d;
            tmo_q        <= tmo_d;
            wen_q        <= wen_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
        end
    end

`ifdef UPG_CHECKSUM_EN
    // Running 8-bit checksum of header and payload bytes
    always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end
`endif

    assign busy       = w_busy;
    assign cpu_hold   = w_busy;
    assign upg_done_o = !w_busy;
    assign err        = (state_q == ERR);
    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;

endmodule
`default_nettype wire

// File: doc/upg_loader_ctrl.md
Name: upg_loader_ctrl

Overview:
Sequences UART program/data download into the shared instruction and data memories through the memory `upg_*` port.
- Holds the CPU stalled while loading.
- Assembles the received byte stream into 32-bit little-endian words.
- Issues one write per word with an auto-incrementing address.
- Releases memory back to the CPU by asserting `upg_done_o`.
- Sits between the UART receiver and the memory/IFetch upgrade ports in `cpu_top`.

Parameters:
- `ADDR_W`, 15, width of `upg_adr_o`; MSB selects memory (0 = instruction, 1 = data), lower bits are the word address.
- `TIMEOUT_CYCLES`, 5000000, maximum idle clocks between bytes while loading before abort.
- `MAX_WORDS`, 32768, largest legal word count (2**`ADDR_W`).

Ports:
- `clk` in 1: CPU clock; all logic on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `prog_start` in 1: level; a rising edge requests a download.
- `rx_valid` in 1: one-cycle strobe, a received byte is on `rx_data`.
- `rx_data` in 8: received byte.
- `cpu_hold` out 1: 1 = CPU PC/regfile writes frozen.
- `upg_wen_o` out 1: memory write enable, one-cycle pulse per word.
- `upg_adr_o` out `ADDR_W`: word address for the current write.
- `upg_dat_o` out 32: write data.
- `upg_done_o` out 1: 1 = memory owned by CPU (normal run).
- `busy` out 1: loader active (`HDR0`..`DATA`/`CHK`).
- `err` out 1: sticky abort flag, cleared by the next accepted start.

Behaviour:
- Reset (`rst`=1 at an edge), in any state including mid-transfer:
  - state `IDLE`
  - `cpu_hold`=0, `upg_wen_o`=0, `upg_adr_o`=0, `upg_dat_o`=0
  - `upg_done_o`=1, `busy`=0, `err`=0
  - internal counters cleared
- `prog_start` edge detection: registered previous value; a start is accepted only in `IDLE`, `DONE` or `ERR`. It is ignored while `busy`.
- States and transitions:
  - `IDLE`/`DONE`/`ERR`, start edge → `HDR0`. Next cycle: `cpu_hold`=1, `upg_done_o`=0, `busy`=1, `err`=0, word count N=0, address=0, byte index=0, timeout counter=0.
  - `HDR0`, `rx_valid` → latch N[7:0], go to `HDR1`.
  - `HDR1`, `rx_valid` → latch N[15:8], then:
    - N=0 → `DONE`
    - N>`MAX_WORDS` → `ERR`
    - otherwise → `DATA`
  - `DATA`: bytes shift into a 32-bit assembly register, little-endian (byte0 → bits 7:0). On the 4th byte of a word:
    - the next cycle drives `upg_wen_o`=1 for exactly one clock, with `upg_dat_o` = assembled word and `upg_adr_o` = current address;
    - the address then increments by 1 (crossing `0x3FFF`→`0x4000` moves from instruction to data memory);
    - the written-word counter increments.
    - When written words reach N, go to `DONE` after the write cycle.
  - `DONE`: `cpu_hold`=0, `upg_done_o`=1, `busy`=0, `upg_wen_o`=0.
  - `ERR`: same outputs as `DONE`, plus `err`=1.
- Latency: write pulse 1 clock after the `rx_valid` of the 4th byte. `upg_done_o` rises 1 clock after the last write pulse.
- Timeout: the counter resets on every `rx_valid` and counts while `busy`. Reaching `TIMEOUT_CYCLES`-1 → `ERR`; already-written words stay written.
- `rx_valid` outside `busy` is ignored.
- `rx_valid` in the same cycle as a write pulse is accepted; the byte goes into the next word.
- `upg_adr_o`/`upg_dat_o` hold their last values between pulses.

Optional Feature:
- Macro: `UPG_CHECKSUM_EN`.
- Defined:
  - After the Nth word, state `CHK` waits for one checksum byte.
  - Required: the 8-bit wrapping sum of all header and data bytes, plus the checksum byte, equals 0x00.
  - Match → `DONE`; mismatch → `ERR`.
  - The timeout applies in `CHK`.
- Undefined: no `CHK` state; `DATA` goes directly to `DONE`.

Decomposition:
- Shared package `upg_pkg`:
  - state enum (`IDLE`, `HDR0`, `HDR1`, `DATA`, `CHK`, `DONE`, `ERR`)
  - `UPG_DMEM_BASE`=15'h4000
  - header byte count constant
- One natural sub-module: `upg_word_assembler` (byte shift register, byte index, word-ready strobe). The FSM, counters and timeout stay in the top module.

Test Plan:
- Reset: `rst`=1 during `DATA` after 2 bytes → next cycle state `IDLE`, `upg_done_o`=1, `cpu_hold`=0, `upg_wen_o`=0, `err`=0.
- Basic load: start, bytes 02 00, EF BE AD DE, 78 56 34 12 → pulses at adr 0 (data 0xDEADBEEF) and adr 1 (data 0x12345678); `upg_done_o`=1 one clock after the second pulse.
- Zero length: start, header 00 00 → `DONE`, no `upg_wen_o` pulse, `cpu_hold` low again.
- Boundary: N=0x4001 → the 16385th write has `upg_adr_o`=0x4000. Header 01 80 (N=0x8001) → `ERR`, `err`=1, no writes.
- Timeout (`TIMEOUT_CYCLES`=100 in the bench): stop after 3 data bytes → `ERR` after 100 idle clocks. A new start edge clears `err` and restarts at adr 0.
- Checksum (`UPG_CHECKSUM_EN`): header 01 00, data 01 02 03 04, checksum 0xF5 → `DONE`. With checksum 0xF4 → `ERR`. A start pulse during `DATA` is ignored.
